// File: rtl/hyperbus_pkg.sv
// Shared state encoding and channel widths for the
// HyperBus transaction arbiter.
package hyperbus_pkg;

  localparam int BURST_WIDTH = 12;
  localparam int NR_CS       = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WDATA,
    RDATA
  } arb_state_t;

endpackage

// File: rtl/hyperbus_rr_arb.sv
// Combinational round-robin pick: first requester at or
// after i_ptr, searching upward modulo NR_PORTS.
module hyperbus_rr_arb
  import hyperbus_pkg::*;
#(
  parameter int NR_PORTS = 2,
  parameter int IW       = $clog2(NR_PORTS)
) (
  input  logic [NR_PORTS-1:0] i_req,
  input  logic [IW-1:0]       i_ptr,
  output logic [NR_PORTS-1:0] o_gnt,
  output logic [IW-1:0]       o_idx
);

  int w_best;
  int w_dist;

  // Smallest upward distance from the pointer wins.
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    w_best = NR_PORTS;
    w_dist = 0;
    for (int j = 0; j < NR_PORTS; j++) begin
      w_dist = (j + NR_PORTS - int'(i_ptr)) % NR_PORTS;
      if (i_req[j] && (w_dist < w_best)) begin
        w_best   = w_dist;
        o_gnt    = '0;
        o_gnt[j] = 1'b1;
        o_idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/hyperbus_trans_arbiter.sv
// Shares one HyperBus PHY transaction/tx/rx port set
// between NR_PORTS requesters, one burst at a time.
module hyperbus_trans_arbiter
  import hyperbus_pkg::*;
#(
  parameter int NR_PORTS    = 2,
  parameter int BURST_WIDTH = hyperbus_pkg::BURST_WIDTH,
  parameter int NR_CS       = hyperbus_pkg::NR_CS
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NR_PORTS-1:0]             req_valid_i,
  output logic [NR_PORTS-1:0]             req_ready_o,
  input  logic [NR_PORTS*32-1:0]          req_address_i,
  input  logic [NR_PORTS*NR_CS-1:0]       req_cs_i,
  input  logic [NR_PORTS-1:0]             req_write_i,
  input  logic [NR_PORTS*BURST_WIDTH-1:0] req_burst_i,
  input  logic [NR_PORTS-1:0]             req_tx_valid_i,
  output logic [NR_PORTS-1:0]             req_tx_ready_o,
  input  logic [NR_PORTS*16-1:0]          req_tx_data_i,
  input  logic [NR_PORTS*2-1:0]           req_tx_strb_i,
  output logic [NR_PORTS-1:0]             req_rx_valid_o,
  input  logic [NR_PORTS-1:0]             req_rx_ready_i,
  output logic [15:0]                     req_rx_data_o,
  output logic                            trans_valid_o,
  input  logic                            trans_ready_i,
  output logic [31:0]                     trans_address_o,
  output logic [NR_CS-1:0]                trans_cs_o,
  output logic                            trans_write_o,
  output logic [BURST_WIDTH-1:0]          trans_burst_o,
  output logic                            tx_valid_o,
  input  logic                            tx_ready_i,
  output logic [15:0]                     tx_data_o,
  output logic [1:0]                      tx_strb_o,
  input  logic                            rx_valid_i,
  output logic                            rx_ready_o,
  input  logic [15:0]                     rx_data_i,
  output logic [NR_PORTS-1:0]             grant_o,
  output logic                            busy_o,
  output logic                            rx_unexpected_o
);

  localparam int IW = $clog2(NR_PORTS);
  localparam logic [BURST_WIDTH-1:0] ONE =
    BURST_WIDTH'(1);

  arb_state_t              r_state;
  arb_state_t              w_next;
  logic [IW-1:0]           r_gidx;
  logic [IW-1:0]           r_ptr;
  logic [NR_PORTS-1:0]     r_gnt;
  logic [BURST_WIDTH-1:0]  r_beats;
  logic                    r_unexp;
  logic [IW-1:0]           w_idx;
  logic [NR_PORTS-1:0]     w_gnt;
  logic                    w_beat;
  logic                    w_last;

  logic [31:0]             w_addr  [NR_PORTS];
  logic [NR_CS-1:0]        w_cs    [NR_PORTS];
  logic [BURST_WIDTH-1:0]  w_burst [NR_PORTS];
  logic [15:0]             w_txd   [NR_PORTS];
  logic [1:0]              w_txs   [NR_PORTS];

  for (genvar p = 0; p < NR_PORTS; p++) begin : g_port
    assign w_addr[p]  = req_address_i[p*32 +: 32];
    assign w_cs[p]    = req_cs_i[p*NR_CS +: NR_CS];
    assign w_burst[p] =
      req_burst_i[p*BURST_WIDTH +: BURST_WIDTH];
    assign w_txd[p]   = req_tx_data_i[p*16 +: 16];
    assign w_txs[p]   = req_tx_strb_i[p*2 +: 2];
  end

  hyperbus_rr_arb #(
    .NR_PORTS (NR_PORTS),
    .IW       (IW)
  ) u_rr_arb (
    .i_req (req_valid_i),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign trans_address_o = w_addr[r_gidx];
  assign trans_cs_o      = w_cs[r_gidx];
  assign trans_write_o   = req_write_i[r_gidx];
  assign trans_burst_o   = w_burst[r_gidx];
  assign tx_data_o       = w_txd[r_gidx];
  assign tx_strb_o       = w_txs[r_gidx];
  assign req_rx_data_o   = rx_data_i;
  assign grant_o         = r_gnt;
  assign busy_o          = (r_state != IDLE);
  assign rx_unexpected_o = r_unexp;
  assign w_last          = w_beat && (r_beats == ONE);

  always_comb begin
    w_next         = r_state;
    trans_valid_o  = 1'b0;
    req_ready_o    = '0;
    tx_valid_o     = 1'b0;
    req_tx_ready_o = '0;
    req_rx_valid_o = '0;
    rx_ready_o     = 1'b1;
    w_beat         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|req_valid_i) w_next = ISSUE;
      end
      ISSUE: begin
        trans_valid_o = 1'b1;
        if (trans_ready_i) begin
          req_ready_o = r_gnt;
          w_next = req_write_i[r_gidx] ? WDATA : RDATA;
        end
      end
      WDATA: begin
        tx_valid_o = req_tx_valid_i[r_gidx];
        if (tx_ready_i) req_tx_ready_o = r_gnt;
        w_beat = req_tx_valid_i[r_gidx] & tx_ready_i;
      end
      RDATA: begin
        if (rx_valid_i) req_rx_valid_o = r_gnt;
        rx_ready_o = req_rx_ready_i[r_gidx];
        w_beat = rx_valid_i & req_rx_ready_i[r_gidx];
      end
      default: w_next = IDLE;
    endcase
    if (w_last) w_next = IDLE;
  end

  // A zero burst wraps through 2^BURST_WIDTH beats.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_gidx  <= '0;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_beats <= '0;
      r_unexp <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && |req_valid_i) begin
        r_gidx <= w_idx;
        r_gnt  <= w_gnt;
      end
      if (r_state == ISSUE && trans_ready_i) begin
        r_beats <= w_burst[r_gidx];
      end
      if (w_beat) r_beats <= r_beats - ONE;
      if (w_last) begin
        r_gnt <= '0;
        if (int'(r_gidx) == NR_PORTS - 1) r_ptr <= '0;
        else r_ptr <= r_gidx + IW'(1);
      end
      if (r_state != RDATA && rx_valid_i) r_unexp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hyperbus_trans_arbiter.sv
// Randomized bench for hyperbus_trans_arbiter against a
// transaction-level round-robin / beat-count model.
module tb_hyperbus_trans_arbiter;

  localparam int NP  = 2;
  localparam int BW  = 12;
  localparam int NCS = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NP-1:0]     req_valid_i;
  logic [NP-1:0]     req_ready_o;
  logic [NP*32-1:0]  req_address_i;
  logic [NP*NCS-1:0] req_cs_i;
  logic [NP-1:0]     req_write_i;
  logic [NP*BW-1:0]  req_burst_i;
  logic [NP-1:0]     req_tx_valid_i;
  logic [NP-1:0]     req_tx_ready_o;
  logic [NP*16-1:0]  req_tx_data_i;
  logic [NP*2-1:0]   req_tx_strb_i;
  logic [NP-1:0]     req_rx_valid_o;
  logic [NP-1:0]     req_rx_ready_i;
  logic [15:0]       req_rx_data_o;
  logic              trans_valid_o;
  logic              trans_ready_i;
  logic [31:0]       trans_address_o;
  logic [NCS-1:0]    trans_cs_o;
  logic              trans_write_o;
  logic [BW-1:0]     trans_burst_o;
  logic              tx_valid_o;
  logic              tx_ready_i;
  logic [15:0]       tx_data_o;
  logic [1:0]        tx_strb_o;
  logic              rx_valid_i;
  logic              rx_ready_o;
  logic [15:0]       rx_data_i;
  logic [NP-1:0]     grant_o;
  logic              busy_o;
  logic              rx_unexpected_o;

  hyperbus_trans_arbiter #(
    .NR_PORTS    (NP),
    .BURST_WIDTH (BW),
    .NR_CS       (NCS)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_address_i   (req_address_i),
    .req_cs_i        (req_cs_i),
    .req_write_i     (req_write_i),
    .req_burst_i     (req_burst_i),
    .req_tx_valid_i  (req_tx_valid_i),
    .req_tx_ready_o  (req_tx_ready_o),
    .req_tx_data_i   (req_tx_data_i),
    .req_tx_strb_i   (req_tx_strb_i),
    .req_rx_valid_o  (req_rx_valid_o),
    .req_rx_ready_i  (req_rx_ready_i),
    .req_rx_data_o   (req_rx_data_o),
    .trans_valid_o   (trans_valid_o),
    .trans_ready_i   (trans_ready_i),
    .trans_address_o (trans_address_o),
    .trans_cs_o      (trans_cs_o),
    .trans_write_o   (trans_write_o),
    .trans_burst_o   (trans_burst_o),
    .tx_valid_o      (tx_valid_o),
    .tx_ready_i      (tx_ready_i),
    .tx_data_o       (tx_data_o),
    .tx_strb_o       (tx_strb_o),
    .rx_valid_i      (rx_valid_i),
    .rx_ready_o      (rx_ready_o),
    .rx_data_i       (rx_data_i),
    .grant_o         (grant_o),
    .busy_o          (busy_o),
    .rx_unexpected_o (rx_unexpected_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;

  logic [31:0]    f_addr  [NP];
  logic [NCS-1:0] f_cs    [NP];
  logic           f_wr    [NP];
  logic [BW-1:0]  f_burst [NP];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic clr_data();
    rx_valid_i     = 1'b0;
    req_tx_valid_i = '0;
    tx_ready_i     = 1'b0;
    req_rx_ready_i = '0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  // One full transaction; bl<0 / wr<0 mean random.
  // pat: 0 random PHY, 1 ready toggles, 2 always ready.
  task automatic run_txn(input logic [NP-1:0] mask,
                         input int bl,
                         input int wr,
                         input int pat,
                         input logic [31:0] afix,
                         output logic [NP-1:0] g_seen);
    int w, n, beats, cyc;
    logic rdy, rxv;
    logic [NP-1:0] tv, rr;
    logic [15:0] d;
    for (int i = 0; i < NP; i++) begin
      f_addr[i]  = (afix != 0) ? afix : $urandom;
      f_cs[i]    = NCS'($urandom);
      f_wr[i]    = (wr < 0) ? 1'($urandom) : 1'(wr);
      f_burst[i] = (bl >= 0) ? BW'(bl)
                             : BW'($urandom_range(1, 5));
      req_address_i[i*32 +: 32] = f_addr[i];
      req_cs_i[i*NCS +: NCS]    = f_cs[i];
      req_write_i[i]            = f_wr[i];
      req_burst_i[i*BW +: BW]   = f_burst[i];
    end
    w = 0;
    for (int k = NP - 1; k >= 0; k--)
      if (mask[(m_ptr + k) % NP]) w = (m_ptr + k) % NP;
    req_valid_i   = mask;
    trans_ready_i = 1'b0;
    #1;
    chk("idle_tvalid", 64'(trans_valid_o), 64'(0));
    chk("idle_busy", 64'(busy_o), 64'(0));
    @(posedge clk_i); #1;
    g_seen = grant_o;
    chk("grant", 64'(grant_o), 64'(1 << w));
    chk("busy", 64'(busy_o), 64'(1));
    chk("tvalid", 64'(trans_valid_o), 64'(1));
    chk("taddr", 64'(trans_address_o), 64'(f_addr[w]));
    chk("tcs", 64'(trans_cs_o), 64'(f_cs[w]));
    chk("twrite", 64'(trans_write_o), 64'(f_wr[w]));
    chk("tburst", 64'(trans_burst_o), 64'(f_burst[w]));
    chk("rdy_wait", 64'(req_ready_o), 64'(0));
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk_i); #1;
      chk("tvalid_hold", 64'(trans_valid_o), 64'(1));
    end
    trans_ready_i = 1'b1;
    #1 chk("req_ready", 64'(req_ready_o), 64'(1 << w));
    @(posedge clk_i); #1;
    trans_ready_i = 1'b0;
    req_valid_i   = '0;
    n = (f_burst[w] == 0) ? (1 << BW) : int'(f_burst[w]);
    beats = 0;
    cyc   = 0;
    while (beats < n && cyc < 20000) begin
      if (pat == 0) rdy = 1'($urandom);
      else if (pat == 1) rdy = (cyc % 2 == 0);
      else rdy = 1'b1;
      d = 16'($urandom);
      if (f_wr[w]) begin
        tv = (pat == 0) ? NP'($urandom) : '1;
        req_tx_valid_i = tv;
        req_tx_data_i  = (NP*16)'($urandom);
        req_tx_strb_i  = (NP*2)'($urandom);
        tx_ready_i     = rdy;
        rx_valid_i     = 1'b0;
        #1;
        chk("tx_valid", 64'(tx_valid_o), 64'(tv[w]));
        chk("tx_data", 64'(tx_data_o),
            64'(req_tx_data_i[w*16 +: 16]));
        chk("tx_strb", 64'(tx_strb_o),
            64'(req_tx_strb_i[w*2 +: 2]));
        chk("tx_ready", 64'(req_tx_ready_o),
            rdy ? 64'(1 << w) : 64'(0));
        chk("wr_rx_iso", 64'(req_rx_valid_o), 64'(0));
        chk("wr_rx_ready", 64'(rx_ready_o), 64'(1));
        if (tv[w] && rdy) beats++;
      end else begin
        rxv = (pat == 0) ? 1'($urandom) : 1'b1;
        rr = NP'($urandom);
        rr[w] = rdy;
        rx_valid_i     = rxv;
        rx_data_i      = d;
        req_rx_ready_i = rr;
        req_tx_valid_i = '1;
        tx_ready_i     = 1'b1;
        #1;
        chk("rx_valid", 64'(req_rx_valid_o),
            rxv ? 64'(1 << w) : 64'(0));
        chk("rx_ready", 64'(rx_ready_o), 64'(rdy));
        chk("rx_data", 64'(req_rx_data_o), 64'(d));
        chk("rd_tx_iso", 64'(req_tx_ready_o), 64'(0));
        chk("rd_tx_valid", 64'(tx_valid_o), 64'(0));
        if (rxv && rdy) beats++;
      end
      @(posedge clk_i); #1;
      cyc++;
      if (beats < n) chk("busy_mid", 64'(busy_o), 64'(1));
    end
    clr_data();
    chk("beats_timeout", 64'(beats), 64'(n));
    chk("done_busy", 64'(busy_o), 64'(0));
    chk("done_grant", 64'(grant_o), 64'(0));
    chk("done_tvalid", 64'(trans_valid_o), 64'(0));
    m_ptr = (w + 1) % NP;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NP-1:0] g;
    int ord [4];
    ord = '{0, 1, 0, 1};
    rst_i          = 1'b1;
    req_valid_i    = '0;
    req_address_i  = '0;
    req_cs_i       = '0;
    req_write_i    = '0;
    req_burst_i    = '0;
    req_tx_data_i  = '0;
    req_tx_strb_i  = '0;
    trans_ready_i  = 1'b0;
    rx_data_i      = '0;
    clr_data();
    do_reset();
    chk("rst_grant", 64'(grant_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_unexp", 64'(rx_unexpected_o), 64'(0));
    chk("rst_tvalid", 64'(trans_valid_o), 64'(0));
    chk("rst_txvalid", 64'(tx_valid_o), 64'(0));
    chk("rst_rxready", 64'(rx_ready_o), 64'(1));
    chk("rst_reqready", 64'(req_ready_o), 64'(0));
    chk("rst_rxvalid", 64'(req_rx_valid_o), 64'(0));

    run_txn(2'b10, 4, 0, 2, 32'h100, g);

    for (int i = 0; i < 4; i++) begin
      run_txn(2'b11, 2, -1, 0, 0, g);
      chk("rr_order", 64'(g), 64'(1 << ord[i]));
    end

    run_txn(2'b01, 3, 1, 1, 0, g);
    run_txn(2'b01, 3, 0, 0, 0, g);

    // Reset on beat 2 of 8; pointer must return to 0.
    req_address_i[31:0] = 32'h200;
    req_write_i[0]      = 1'b0;
    req_burst_i[BW-1:0] = BW'(8);
    req_valid_i         = 2'b01;
    @(posedge clk_i); #1;
    chk("rm_grant", 64'(grant_o), 64'(1));
    trans_ready_i = 1'b1;
    @(posedge clk_i); #1;
    trans_ready_i  = 1'b0;
    req_valid_i    = '0;
    rx_valid_i     = 1'b1;
    req_rx_ready_i = '1;
    @(posedge clk_i); #1;
    chk("rm_busy_b1", 64'(busy_o), 64'(1));
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    clr_data();
    chk("rm_busy", 64'(busy_o), 64'(0));
    chk("rm_grant0", 64'(grant_o), 64'(0));
    chk("rm_tvalid", 64'(trans_valid_o), 64'(0));
    chk("rm_rxready", 64'(rx_ready_o), 64'(1));
    m_ptr = 0;
    run_txn(2'b11, 2, 0, 2, 0, g);

    rx_valid_i = 1'b1;
    rx_data_i  = 16'hbeef;
    #1;
    chk("stray_ready", 64'(rx_ready_o), 64'(1));
    chk("stray_pre", 64'(rx_unexpected_o), 64'(0));
    chk("stray_iso", 64'(req_rx_valid_o), 64'(0));
    @(posedge clk_i); #1;
    rx_valid_i = 1'b0;
    chk("stray_set", 64'(rx_unexpected_o), 64'(1));

    for (int i = 0; i < 12; i++) begin
      run_txn(NP'($urandom_range(1, 3)), -1, -1, 0, 0, g);
      chk("unexp_sticky", 64'(rx_unexpected_o), 64'(1));
    end

    do_reset();
    m_ptr = 0;
    chk("unexp_clr", 64'(rx_unexpected_o), 64'(0));

    run_txn(2'b11, 0, 0, 2, 0, g);
    run_txn(2'b11, -1, 1, 0, 0, g);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hyperbus_trans_arbiter.md
# hyperbus_trans_arbiter

Round-robin arbiter that shares one `hyperbus_phy` transaction/tx/rx port set between `NR_PORTS` requesters, such as separate AXI read and write front-ends or several masters. It grants one requester at a time and forwards that requester's transaction to the PHY. It holds the grant until the granted requester has moved the full burst of data beats, then releases it. It sits directly between the requesters and the PHY, in the PHY's `clk0` domain.

## Interface
Parameters:
- `NR_PORTS`, 2, number of requesters (≥2)
- `BURST_WIDTH`, 12, burst-length field width; must match the PHY
- `NR_CS`, 2, chip-select width; must match the PHY

Ports:
- `clk_i` in 1: single clock. Everything is on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_valid_i` / `req_ready_o` in/out `NR_PORTS`: per-port transaction handshake.
- `req_address_i` in `NR_PORTS`×32: per-port transaction address.
- `req_cs_i` in `NR_PORTS`×`NR_CS`: per-port chip select.
- `req_write_i` in `NR_PORTS`: per-port write flag.
- `req_burst_i` in `NR_PORTS`×`BURST_WIDTH`: per-port burst length in 16-bit beats.
- `req_tx_valid_i` / `req_tx_ready_o` in/out `NR_PORTS`: per-port write-data handshake.
- `req_tx_data_i` in `NR_PORTS`×16, `req_tx_strb_i` in `NR_PORTS`×2: per-port write data and strobes.
- `req_rx_valid_o` / `req_rx_ready_i` out/in `NR_PORTS`: per-port read-data handshake.
- `req_rx_data_o` out 16: read data, broadcast to all ports.
- `trans_valid_o` / `trans_ready_i`, `trans_address_o` 32, `trans_cs_o` `NR_CS`, `trans_write_o` 1, `trans_burst_o` `BURST_WIDTH`: PHY transaction channel.
- `tx_valid_o` / `tx_ready_i`, `tx_data_o` 16, `tx_strb_o` 2: PHY write-data channel.
- `rx_valid_i` / `rx_ready_o`, `rx_data_i` 16: PHY read-data channel.
- `grant_o` out `NR_PORTS`: one-hot owner, or 0 when idle.
- `busy_o` out 1: high whenever the state is not IDLE.
- `rx_unexpected_o` out 1: sticky flag for a read beat that arrived with no read owner.

## Operation
- State machine: IDLE → ISSUE → WDATA or RDATA → IDLE.
- **IDLE:**
  - If any `req_valid_i` bit is set, register the grant index and go to ISSUE.
  - The winner is the first requesting port at or after `rr_ptr`, searching upward modulo `NR_PORTS`.
- **ISSUE:**
  - `trans_*_o` carry the granted port's fields and `trans_valid_o`=1.
  - `req_ready_o[g]` = `trans_ready_i`; every other port's ready is 0.
  - On handshake, load `beats_left` ← `req_burst_i[g]`, then go to WDATA if the write flag is set, otherwise RDATA.
- **WDATA:** the granted port's tx channel is connected to the PHY tx channel. Other ports' `req_tx_ready_o` = 0.
- **RDATA:**
  - `req_rx_valid_o[g]` = `rx_valid_i` and `rx_ready_o` = `req_rx_ready_i[g]`.
  - Other ports' `req_rx_valid_o` = 0.
- **Beat counting:**
  - A beat counts on each tx or rx handshake, and `beats_left` decrements modulo 2^`BURST_WIDTH`.
  - On the beat that sees `beats_left`==1: go to IDLE and set `rr_ptr` ← (g+1) mod `NR_PORTS`.
  - A burst of 0 wraps to give 2^`BURST_WIDTH` beats, which matches the PHY's own count.
- **Unexpected read beats:** outside RDATA, `rx_ready_o`=1, so any PHY read beat is consumed and dropped, and `rx_unexpected_o` is set. Only reset clears it.
- **Request stability:** requesters hold their `req_*` fields stable while valid is high. The arbiter never withdraws `trans_valid_o` once it is asserted.

## Timing
- Reset values:
  - state IDLE, `rr_ptr`=0, `beats_left`=0;
  - `grant_o`=0, `busy_o`=0, `rx_unexpected_o`=0;
  - all valid and ready outputs 0, except `rx_ready_o`=1.
- Arbitration latency: `trans_valid_o` rises one cycle after `req_valid_i`, if sampled in IDLE.
- Data-path valids, readies and data are combinational pass-throughs; no added latency.
- Gap between back-to-back transactions: one IDLE cycle, from the last beat to the next ISSUE.
- Simultaneous requests: round-robin only; there is no fixed priority. A port that withdraws its request in IDLE simply loses eligibility.
- Reset during ISSUE or a data phase: next cycle, reset values as above. The PHY must be reset in the same cycle.

## Structure
- `hyperbus_pkg` holds:
  - the `arb_state_t` enum {IDLE, ISSUE, WDATA, RDATA};
  - the shared widths `BURST_WIDTH` and `NR_CS`.
- Sub-module `hyperbus_rr_arb`:
  - inputs: the request vector and `rr_ptr`;
  - outputs: a one-hot grant and its index;
  - purely combinational.
- The FSM, counter and channel muxes stay in the top module.

## Test plan
- **Single read:** port 1 issues addr 0x100, burst 4, write=0. Expect `trans_valid_o` one cycle later with address 0x100; 4 rx beats reach port 1 only; then `busy_o`=0.
- **Contention:** ports 0 and 1 both hold valid from reset. Expect grant order 0,1,0,1 across four transactions of burst 2.
- **Write backpressure:** port 0 issues burst 3, write=1. `tx_ready_i` toggles 1,0,1,0,1. Expect exactly 3 beats forwarded and the grant released after the third.
- **Isolation:**
  - While port 0 owns RDATA, port 1 asserting tx_valid gets `req_tx_ready_o[1]`=0.
  - While port 0 owns RDATA, `req_rx_valid_o[1]` stays 0.
- **Stray read:** an rx beat arrives in IDLE. Expect it consumed and `rx_unexpected_o`=1, held until `rst_i`.
- **Reset mid-burst:** `rst_i` asserted on beat 2 of 8. Next cycle: IDLE, `grant_o`=0, `rr_ptr`=0.
